// File: rtl/gf2mz_reduce_pkg.sv
// Shared definitions for the GF(2^m)[z] product reduction stage:
// default field/ring parameters, derived depths, FSM encoding, slice helpers.
package gf2mz_reduce_pkg;

   function automatic int CLOG2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

   localparam int N_DEF = 47;
   localparam int M_DEF = 79;
   localparam int D_DEF = 5;
   localparam int K_DEF = 5;

   localparam int DEPTH_DEF  = (N_DEF + D_DEF - 1) / D_DEF;
   localparam int PDEPTH_DEF = (2 * N_DEF - 1 + D_DEF - 1) / D_DEF;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FOLD  = 3'd2,
      S_STORE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Coefficient idx lives in word idx/d; slice 0 sits in the MSBs.
   function automatic int coef_word(input int idx, input int d);
      return idx / d;
   endfunction

   function automatic int coef_lsb(input int idx, input int m, input int d);
      return (d - 1 - idx % d) * m;
   endfunction

endpackage

// File: rtl/gf2mz_reduce.sv
// Reads product C(z) from memory, reduces mod z^n+z^k+1, writes R(z).
// Ports: clk, rst_b, start | C_addr/C_di (read) | R_addr/R_do/R_we | busy, done.
module gf2mz_reduce
   import gf2mz_reduce_pkg::*;
#(
   parameter int n      = N_DEF,
   parameter int m      = M_DEF,
   parameter int d      = D_DEF,
   parameter int k      = K_DEF,
   parameter int WIDTH  = m * d,
   parameter int DEPTH  = (n + d - 1) / d,
   parameter int PDEPTH = (2 * n - 1 + d - 1) / d
) (
   input  logic                        clk,
   input  logic                        rst_b,
   input  logic                        start,
   output logic [CLOG2(PDEPTH)-1:0]    C_addr,
   input  logic [WIDTH-1:0]            C_di,
   output logic [CLOG2(DEPTH)-1:0]     R_addr,
   output logic [WIDTH-1:0]            R_do,
   output logic                        R_we,
   output logic                        busy,
   output logic                        done
);

   localparam int AW = CLOG2(PDEPTH);
   localparam int RW = CLOG2(DEPTH);
   localparam int CW = CLOG2(2 * n);
   localparam int NC = 2 * n - 1;

   localparam logic [CW-1:0] CNT_PLAST = CW'(PDEPTH);
   localparam logic [CW-1:0] CNT_JTOP  = CW'(2 * n - 2);
   localparam logic [CW-1:0] CNT_JBOT  = CW'(n);
   localparam logic [CW-1:0] CNT_SLAST = CW'(DEPTH - 1);

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [m-1:0]    h   [NC];
   logic [m-1:0]    h_n [NC];
   logic [m-1:0]    hj;
   logic [WIDTH-1:0] rdo_n;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         S_IDLE:
            if (start) begin
               state_n = S_LOAD;
               cnt_n   = '0;
            end
         S_LOAD:
            if (cnt == CNT_PLAST) begin
               state_n = S_FOLD;
               cnt_n   = CNT_JTOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         S_FOLD:
            if (cnt == CNT_JBOT) begin
               state_n = S_STORE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         S_STORE:
            if (cnt == CNT_SLAST) begin
               state_n = S_DONE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         S_DONE:
            state_n = S_IDLE;
         default:
            state_n = S_IDLE;
      endcase
   end

   // In LOAD, the word arriving now was addressed at cnt-1.
   // In FOLD, cnt is the exponent j being folded away.
   always_comb begin
      h_n = h;
      hj  = '0;
      if (state == S_LOAD && cnt != '0) begin
         for (int i = 0; i < NC; i++)
            if (coef_word(i, d) == int'(cnt) - 1)
               h_n[i] = C_di[coef_lsb(i, m, d) +: m];
      end else if (state == S_FOLD) begin
         for (int i = 0; i < NC; i++)
            if (CW'(i) == cnt) hj = h[i];
         for (int i = 0; i < NC; i++)
            if (i == int'(cnt) - n || i == int'(cnt) - n + k)
               h_n[i] = h[i] ^ hj;
      end
   end

   always_ff @(posedge clk)
      h <= h_n;

   // Packs from h_n so the first STORE word sees the last fold step.
   always_comb begin
      rdo_n = '0;
      if (state_n == S_STORE)
         for (int i = 0; i < n; i++)
            if (coef_word(i, d) == int'(cnt_n))
               rdo_n[coef_lsb(i, m, d) +: m] = h_n[i];
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state  <= S_IDLE;
         cnt    <= '0;
         C_addr <= '0;
         R_addr <= '0;
         R_do   <= '0;
         R_we   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         C_addr <= (state_n == S_LOAD && cnt_n < CNT_PLAST)
                   ? AW'(cnt_n) : '0;
         R_we   <= (state_n == S_STORE);
         R_addr <= (state_n == S_STORE) ? RW'(cnt_n) : '0;
         R_do   <= rdo_n;
         busy   <= (state_n != S_IDLE);
         done   <= (state_n == S_DONE);
      end
   end

endmodule

// File: tb/tb_gf2mz_reduce.sv
// Randomized self-checking bench for gf2mz_reduce against a
// z^j mod P(z) reference model; also checks protocol and timing.
module tb_gf2mz_reduce;
   import gf2mz_reduce_pkg::*;

   localparam int N      = N_DEF;
   localparam int M      = M_DEF;
   localparam int D      = D_DEF;
   localparam int K      = K_DEF;
   localparam int W      = M * D;
   localparam int DEPTH  = DEPTH_DEF;
   localparam int PDEPTH = PDEPTH_DEF;
   localparam int NC     = 2 * N - 1;
   localparam int AW     = CLOG2(PDEPTH);
   localparam int RW     = CLOG2(DEPTH);

   logic          clk = 1'b0;
   logic          rst_b = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] C_addr;
   logic [W-1:0]  C_di = '0;
   logic [RW-1:0] R_addr;
   logic [W-1:0]  R_do;
   logic          R_we;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   logic [W-1:0] cmem [PDEPTH];

   always @(posedge clk)
      C_di <= cmem[C_addr];

   gf2mz_reduce dut (
      .clk    (clk),
      .rst_b  (rst_b),
      .start  (start),
      .C_addr (C_addr),
      .C_di   (C_di),
      .R_addr (R_addr),
      .R_do   (R_do),
      .R_we   (R_we),
      .busy   (busy),
      .done   (done)
   );

   int checks = 0;
   int errors = 0;

   logic [M-1:0] coef [NC];
   logic [M-1:0] res  [N];
   logic [W-1:0] rgot [DEPTH];
   logic [M-1:0] xpat;

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [M-1:0] rnd_coef();
      return M'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic clear_coef();
      for (int i = 0; i < NC; i++) coef[i] = '0;
   endtask

   task automatic rand_coef();
      for (int i = 0; i < NC; i++) coef[i] = rnd_coef();
   endtask

   task automatic load_c(input bit garbage);
      for (int w = 0; w < PDEPTH; w++) cmem[w] = '0;
      for (int i = 0; i < NC; i++)
         cmem[coef_word(i, D)][coef_lsb(i, M, D) +: M] = coef[i];
      if (garbage)
         for (int i = NC; i < PDEPTH * D; i++)
            cmem[coef_word(i, D)][coef_lsb(i, M, D) +: M] = rnd_coef() | 1;
   endtask

   // Each z^j is reduced to a GF(2) polynomial r_j of degree < N by
   // repeated multiply-by-z; coefficient c_j then lands on every set bit.
   task automatic ref_reduce();
      logic [N:0] r, p;
      p = '0;
      p[N] = 1'b1;
      p[K] = 1'b1;
      p[0] = 1'b1;
      r = '0;
      r[0] = 1'b1;
      for (int i = 0; i < N; i++) res[i] = '0;
      for (int j = 0; j < NC; j++) begin
         if (j > 0) begin
            r = r << 1;
            if (r[N]) r = r ^ p;
         end
         for (int i = 0; i < N; i++)
            if (r[i]) res[i] = res[i] ^ coef[j];
      end
   endtask

   task automatic expect_r(input string tag);
      logic [W-1:0] exp;
      for (int w = 0; w < DEPTH; w++) begin
         exp = '0;
         for (int t = 0; t < D; t++)
            if (w * D + t < N)
               exp[coef_lsb(w * D + t, M, D) +: M] = res[w * D + t];
         check($sformatf("%s_w%0d", tag, w), rgot[w], exp);
      end
   endtask

   task automatic run_op(input string tag, input int poke_cyc);
      int cyc, bcnt, wcnt, wfirst, wlast, aerr, caerr, extra;
      bcnt = 0; wcnt = 0; wfirst = 0; wlast = 0;
      aerr = 0; caerr = 0; extra = 0;
      for (int w = 0; w < DEPTH; w++) rgot[w] = '1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 1;
      while (1) begin
         start = (cyc == poke_cyc);
         if (busy) bcnt++;
         if (R_we) begin
            if (int'(R_addr) != wcnt) aerr++;
            if (wcnt == 0) wfirst = cyc;
            wlast = cyc;
            wcnt++;
            rgot[R_addr] = R_do;
         end
         if (cyc < PDEPTH + 1) begin
            if (int'(C_addr) != cyc - 1) caerr++;
         end else if (C_addr != '0) begin
            caerr++;
         end
         if (done || cyc >= 200) break;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({tag, "_done_cyc"}, W'(cyc), W'(77));
      check({tag, "_busy_w"}, W'(bcnt), W'(77));
      check({tag, "_we_cnt"}, W'(wcnt), W'(DEPTH));
      check({tag, "_we_span"}, W'(wlast - wfirst), W'(DEPTH - 1));
      check({tag, "_r_addr"}, W'(aerr), W'(0));
      check({tag, "_c_addr"}, W'(caerr), W'(0));
      repeat (30) begin
         @(negedge clk);
         if (busy || done || R_we) extra++;
      end
      check({tag, "_idle_after"}, W'(extra), W'(0));
      expect_r(tag);
   endtask

   initial begin
      xpat = 79'h5A5A5A5A5A5A5A5A5A5;
      for (int w = 0; w < PDEPTH; w++) cmem[w] = '0;
      repeat (3) @(negedge clk);
      check("rst_ctl", W'({busy, done, R_we, C_addr, R_addr}), '0);
      check("rst_rdo", R_do, '0);
      rst_b = 1'b1;
      repeat (2) @(negedge clk);

      clear_coef();
      coef[0] = M'(1);
      load_c(1'b0);
      ref_reduce();
      run_op("one", 0);

      clear_coef();
      coef[N] = xpat;
      load_c(1'b0);
      ref_reduce();
      run_op("c47", 0);

      clear_coef();
      coef[NC - 1] = xpat;
      load_c(1'b0);
      ref_reduce();
      run_op("c92", 0);

      for (int r = 0; r < 3; r++) begin
         rand_coef();
         load_c(1'b1);
         ref_reduce();
         run_op($sformatf("rnd%0d", r), 0);
      end

      rand_coef();
      load_c(1'b1);
      ref_reduce();
      run_op("poke", 30);

      rand_coef();
      load_c(1'b1);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (29) @(negedge clk);
      check("pre_rst_busy", W'(busy), W'(1));
      rst_b = 1'b0;
      #1;
      check("mid_rst_ctl", W'({busy, done, R_we, C_addr, R_addr}), '0);
      check("mid_rst_rdo", R_do, '0);
      @(negedge clk) rst_b = 1'b1;
      rand_coef();
      load_c(1'b1);
      ref_reduce();
      run_op("after_rst", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
